// File: rtl/riscv_pkg.sv
// Shared RV64 front-end types: data widths, fetch FSM states and the
// buffered fetch entry carried from imem response to decode.
package riscv_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  // Clear the two low address bits to form a word-aligned PC.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           empties the FIFO (wins over push/pop)
//   push, push_data write an entry (accepted when not full or popping)
//   pop             remove head entry (ignored when empty)
//   head            current head entry (register read, zero after reset)
//   empty, count    occupancy status
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  output fetch_entry_t  head,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push at full is legal only when the head leaves in the same cycle.
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage; cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// RV64 instruction fetch stage. Owns the fetch PC, issues in-order word
// requests to imem, buffers returned words with their PCs and presents them
// to decode. Redirects flush the buffer and discard in-flight responses.
// Optional macro FETCH_ALIGN_CHECK_EN: a misaligned redirect raises a sticky
// fetch_fault_o and halts fetch until an aligned redirect.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   imem_req_valid/ready/addr    request channel (addr = fetch PC)
//   imem_rsp_valid/data          in-order responses, always accepted
//   redirect_i, redirect_pc_i    branch/jump redirect
//   instr_valid/ready, instr_o, instr_pc_o   decode handoff
//   fetch_fault_o                misaligned redirect fault
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC        = 64'h0000_0000_8000_0000,
  parameter int unsigned     FIFO_DEPTH      = 2,
  parameter int unsigned     MAX_OUTSTANDING = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [ILEN-1:0] imem_rsp_data_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [ILEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  output logic            fetch_fault_o
);

  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [OW-1:0]   out_q, out_d;
  logic [OW-1:0]   drop_q, drop_d;
  logic [OW-1:0]   out_net;
  logic            fault_q, fault_d;
  logic            bad_pc;
  logic            rsp_live;
  logic            credit_ok;
  logic            push;
  logic            flush;
  fetch_entry_t    push_data;
  fetch_entry_t    head;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;

  assign imem_req_addr_o = fetch_pc_q;
  assign fetch_fault_o   = fault_q;
  assign instr_valid_o   = !fifo_empty;
  assign instr_o         = head.instr;
  assign instr_pc_o      = head.pc;
  assign push_data       = '{pc: rsp_pc_q, instr: imem_rsp_data_i};

  // Live (non-dropped) requests plus buffered entries must fit the FIFO.
  assign credit_ok = (32'(out_q) - 32'(drop_q) + 32'(fifo_count)) < FIFO_DEPTH;
  // Stray responses with nothing outstanding are ignored.
  assign rsp_live  = imem_rsp_valid_i && (out_q != '0);
  assign out_net   = out_q - OW'(rsp_live);

  // State registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      fault_q    <= fault_d;
    end
  end

  // Next state, issue, response accounting and redirect handling.
  always_comb begin
    state_d          = state_q;
    fetch_pc_d       = fetch_pc_q;
    rsp_pc_d         = rsp_pc_q;
    out_d            = out_q;
    drop_d           = drop_q;
    fault_d          = fault_q;
    push             = 1'b0;
    flush            = 1'b0;
    bad_pc           = 1'b0;
    imem_req_valid_o = 1'b0;

`ifdef FETCH_ALIGN_CHECK_EN
    bad_pc = redirect_pc_i[1:0] != 2'b00;
`endif

    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase

    if (redirect_i) begin
      // Everything still in flight after this cycle's response is stale.
      flush      = 1'b1;
      fetch_pc_d = word_align(redirect_pc_i);
      rsp_pc_d   = word_align(redirect_pc_i);
      out_d      = out_net;
      drop_d     = out_net;
      state_d    = bad_pc ? HALT : RUN;
      fault_d    = bad_pc;
    end else begin
      imem_req_valid_o = (state_q == RUN) && (out_q < OW'(MAX_OUTSTANDING)) && credit_ok;
      out_d = out_net + OW'(imem_req_valid_o && imem_req_ready_i);
      if (imem_req_valid_o && imem_req_ready_i) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (rsp_live) begin
        if (drop_q != '0) begin
          drop_d = drop_q - OW'(1);
        end else begin
          push     = 1'b1;
          rsp_pc_d = rsp_pc_q + XLEN'(4);
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .flush     (flush),
    .push      (push),
    .push_data (push_data),
    .pop       (instr_valid_o && instr_ready_i),
    .head      (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized bench for fetch_unit with an in-order imem model
// and a sequential-PC reference for the decode stream.
module tb_fetch_unit;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        fault;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  int          last_due = 0;
  int          n_issued = 0;
  int          n_cons = 0;
  int          n0;
  logic        rnd = 1'b0;
  logic        hit;
  logic [63:0] exp_pc;
  logic [63:0] exp_req;
  logic [63:0] pend_addr[$];
  int          pend_due[$];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .imem_req_valid_o (req_valid),
    .imem_req_ready_i (req_ready),
    .imem_req_addr_o  (req_addr),
    .imem_rsp_valid_i (rsp_valid),
    .imem_rsp_data_i  (rsp_data),
    .redirect_i       (redirect),
    .redirect_pc_i    (redirect_pc),
    .instr_valid_o    (instr_valid),
    .instr_ready_i    (instr_ready),
    .instr_o          (instr),
    .instr_pc_o       (instr_pc),
    .fetch_fault_o    (fault)
  );

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Drive this cycle's inputs: optional random controls, then the memory response.
  task automatic prep();
    if (rnd) begin
      req_ready   = 1'($urandom_range(0, 1));
      instr_ready = ($urandom_range(0, 3) != 0);
      lat         = int'($urandom_range(1, 4));
      if ($urandom_range(0, 49) == 0) begin
        redirect    = 1'b1;
        redirect_pc = 64'h8000_4000 + 64'($urandom_range(0, 255) << 2);
      end
    end
    rsp_valid = 1'b0;
    rsp_data  = '0;
    if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
      rsp_valid = 1'b1;
      rsp_data  = word_of(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
  endtask

  // Sample handshakes against the reference, then advance one clock.
  task automatic finish();
    #1;
    if (redirect) begin
      chk("req_in_redirect", 64'(req_valid), 64'd0);
      exp_pc  = redirect_pc & ~64'h3;
      exp_req = exp_pc;
    end else begin
      if (req_valid && req_ready) begin
        chk("req_addr", req_addr, exp_req);
        pend_addr.push_back(req_addr);
        last_due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
        pend_due.push_back(last_due);
        checks++;
        assert (pend_addr.size() <= 2) else begin
          errors++;
          $error("FAIL outstanding_max got=%0d want<=2", pend_addr.size());
        end
        exp_req += 64'd4;
        n_issued++;
      end
      if (instr_valid && instr_ready) begin
        chk("instr_pc", instr_pc, exp_pc);
        chk("instr_word", 64'(instr), 64'(word_of(exp_pc)));
        exp_pc += 64'd4;
        n_cons++;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    redirect = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      prep();
      finish();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
    redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_valid", 64'(req_valid), 64'd0);
    chk("rst_req_addr", req_addr, RST_PC);
    chk("rst_instr_valid", 64'(instr_valid), 64'd0);
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_instr_pc", instr_pc, 64'd0);
    chk("rst_fault", 64'(fault), 64'd0);

    // BOOT lasts one cycle with no request.
    rst = 1'b0;
    #1;
    chk("boot_no_req", 64'(req_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("run_req_valid", 64'(req_valid), 64'd1);
    chk("run_req_addr", req_addr, RST_PC);
    exp_pc  = RST_PC;
    exp_req = RST_PC;

    // Streaming with ready memory and decode.
    req_ready = 1'b1; instr_ready = 1'b1; lat = 1;
    n0 = n_cons;
    cycles(12);
    chk("stream_count", 64'((n_cons - n0) >= 3), 64'd1);

    // Decode stalled: only FIFO_DEPTH requests may issue.
    req_ready = 1'b0;
    cycles(6);
    chk("drained", 64'(instr_valid), 64'd0);
    instr_ready = 1'b0; req_ready = 1'b1;
    n0 = n_issued;
    cycles(8);
    chk("credit_issued", 64'(n_issued - n0), 64'd2);
    chk("credit_stall", 64'(req_valid), 64'd0);
    chk("full_valid", 64'(instr_valid), 64'd1);
    instr_ready = 1'b1;
    cycles(1);
    chk("req_after_pop", 64'(req_valid), 64'd1);

    // Redirect with two requests in flight.
    req_ready = 1'b0;
    cycles(6);
    lat = 3; req_ready = 1'b1;
    cycles(2);
    chk("two_outstanding", 64'(pend_addr.size()), 64'd2);
    redirect = 1'b1; redirect_pc = 64'h8000_1000;
    prep();
    finish();
    chk("flush_redirect", 64'(instr_valid), 64'd0);
    lat = 1;
    n0 = n_cons;
    cycles(12);
    chk("stream_after_redirect", 64'((n_cons - n0) >= 2), 64'd1);

    // Redirect coinciding with a response and a pop.
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      prep();
      if (rsp_valid && instr_valid) begin
        redirect = 1'b1; redirect_pc = 64'h8000_2000; hit = 1'b1;
      end
      finish();
    end
    chk("same_cycle_hit", 64'(hit), 64'd1);
    chk("flush_same_cycle", 64'(instr_valid), 64'd0);
    n0 = n_cons;
    cycles(12);
    chk("stream_after_same_cycle", 64'((n_cons - n0) >= 2), 64'd1);

`ifdef FETCH_ALIGN_CHECK_EN
    redirect = 1'b1; redirect_pc = 64'h8000_0002;
    prep();
    finish();
    chk("fault_set", 64'(fault), 64'd1);
    n0 = n_issued;
    cycles(6);
    chk("halt_no_issue", 64'(n_issued - n0), 64'd0);
    chk("halt_req_valid", 64'(req_valid), 64'd0);
    chk("fault_sticky", 64'(fault), 64'd1);
    chk("halt_instr_valid", 64'(instr_valid), 64'd0);
    redirect = 1'b1; redirect_pc = 64'h8000_0100;
    prep();
    finish();
    chk("fault_clear", 64'(fault), 64'd0);
    n0 = n_cons;
    cycles(12);
    chk("resume_after_fault", 64'((n_cons - n0) >= 2), 64'd1);
`else
    // Low redirect bits are ignored: fetch resumes at the aligned word.
    redirect = 1'b1; redirect_pc = 64'h8000_3002;
    prep();
    finish();
    chk("no_fault", 64'(fault), 64'd0);
    n0 = n_cons;
    cycles(12);
    chk("stream_misaligned", 64'((n_cons - n0) >= 2), 64'd1);
`endif

    // Random handshakes, latencies and redirects, then drain.
    rnd = 1'b1;
    cycles(600);
    rnd = 1'b0; redirect = 1'b0; req_ready = 1'b0; instr_ready = 1'b1; lat = 1;
    cycles(20);
    chk("no_loss", exp_pc, exp_req);
    chk("final_empty", 64'(instr_valid), 64'd0);
    chk("final_pending", 64'(pend_addr.size()), 64'd0);

    // Reset mid-operation clears state.
    req_ready = 1'b1;
    cycles(3);
    pend_addr.delete();
    pend_due.delete();
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst2_req_valid", 64'(req_valid), 64'd0);
    chk("rst2_req_addr", req_addr, RST_PC);
    chk("rst2_instr_valid", 64'(instr_valid), 64'd0);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
